// File: rtl/acl_spi_reader.sv
// acl_spi_reader: SPI master that configures an accelerometer and samples X/Y/Z into a packed sign/magnitude word
// Ports: ClkPort/Reset system clock and sync active-high reset; miso/sclk/mosi/cs_n SPI mode 0 bus;
// acl_data {x_sign,x_mag,y_sign,y_mag,z_sign,z_mag}; data_valid one-cycle pulse on each acl_data update.
module acl_spi_reader #(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 10_000_000
) (
  input  logic        ClkPort,
  input  logic        Reset,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [14:0] acl_data,
  output logic        data_valid
);
  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_END  = TW'(SAMPLE_PERIOD - 1);
  typedef enum logic [2:0] {BOOT, CFG, GAP, WAIT, READ, UPDATE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          run_q, run_d;
  logic          pend_q, pend_d;
  logic [23:0]   rx_q, rx_d;
  logic [14:0]   acl_q, acl_d;
  logic          in_frame, tail, half_end, running, wrap;
  logic [2:0]    nbytes;
  logic [7:0]    tx_byte;
  // Magnitude is taken at 9 bits so -128 becomes 128, then scaled to 4 bits with saturation.
  function automatic logic [4:0] conv(input logic [7:0] v);
    logic [8:0] abs9;
    abs9 = v[7] ? 9'd0 - {v[7], v} : {1'b0, v};
    return {v[7], abs9[8:7] != 2'b00 ? 4'hF : abs9[6:3]};
  endfunction
  always_comb begin
    in_frame   = state_q == CFG || state_q == READ;
    nbytes     = state_q == READ ? 3'd5 : 3'd3;
    tail       = byte_q == nbytes;
    half_end   = cnt_q == HALF_END;
    tx_byte    = state_q == CFG ? (byte_q == 3'd0 ? 8'h0A : byte_q == 3'd1 ? 8'h2D : 8'h02)
                                : (byte_q == 3'd0 ? 8'h0B : byte_q == 3'd1 ? 8'h08 : 8'h00);
    running    = run_q || state_q == WAIT;
    wrap       = running && tmr_q == TMR_END;
    cs_n       = !in_frame;
    sclk       = sclk_q;
    mosi       = in_frame && !tail && tx_byte[3'd7 - bit_q];
    acl_data   = acl_q;
    data_valid = state_q == UPDATE;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    rx_d    = rx_q;
    acl_d   = acl_q;
    run_d   = running;
    tmr_d   = running ? (wrap ? '0 : tmr_q + 1'b1) : '0;
    // A wrap outside WAIT leaves one read pending; further wraps just keep it set.
    pend_d  = pend_q || wrap;
    case (state_q)
      BOOT: state_d = CFG;
      CFG, READ: begin
        if (tail) begin
          // sclk stays low for one more half period before cs_n is released
          if (half_end) begin
            cnt_d   = '0;
            byte_d  = '0;
            state_d = state_q == READ ? UPDATE : GAP;
            if (state_q == READ) acl_d = {conv(rx_q[23:16]), conv(rx_q[15:8]), conv(rx_q[7:0])};
          end else cnt_d = cnt_q + 1'b1;
        end else if (!half_end) cnt_d = cnt_q + 1'b1;
        else begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          // miso is captured on the edge where sclk rises, only for the three data bytes of a read
          if (!sclk_q && state_q == READ && byte_q >= 3'd2) rx_d = {rx_q[22:0], miso};
          if (sclk_q) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) byte_d = byte_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = pend_q || wrap ? READ : WAIT;
          if (pend_q || wrap) pend_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT: begin
        if (pend_q || wrap) begin
          state_d = READ;
          pend_d  = 1'b0;
        end
      end
      UPDATE: state_d = GAP;
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      bit_q   <= '0;
      byte_q  <= '0;
      tmr_q   <= '0;
      run_q   <= 1'b0;
      pend_q  <= 1'b0;
      rx_q    <= '0;
      acl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tmr_q   <= tmr_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      rx_q    <= rx_d;
      acl_q   <= acl_d;
    end
  end
endmodule

// File: tb/tb_acl_spi_reader.sv
// tb_acl_spi_reader: randomized slave plus bus monitor checking acl_spi_reader against a frame-level model
module tb_acl_spi_reader;
  localparam int CLK_DIV = 4;
  localparam int SP      = 300;
  logic clk = 0, Reset, miso, sclk, mosi, cs_n, data_valid;
  logic [14:0] acl_data;
  int errors = 0, checks = 0;
  acl_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP)) dut (
    .ClkPort(clk), .Reset(Reset), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .acl_data(acl_data), .data_valid(data_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] ref_axis(input logic [7:0] v);
    int s, a;
    s = $signed(v);
    a = s < 0 ? -s : s;
    a = a / 8;
    if (a > 15) a = 15;
    return {v[7], 4'(a)};
  endfunction
  logic        prev_cs = 1, prev_sclk = 0, prev_mosi = 0, prev_dv = 0;
  logic [14:0] prev_acl = 0;
  logic        in_frame = 0, expect_cfg = 1, last_rd = 0;
  logic [39:0] mosi_bits, resp;
  logic [14:0] exp_q[$];
  int rises = 0, cyc = 0, gap = 1000, rd_idx = 0, n_dv = 0, n_cfg = 0;
  int v_mosi = 0, v_idle = 0, v_period = 0, v_gap = 0, v_b2b = 0, v_dvw = 0, v_hold = 0;
  always @(negedge clk) begin
    if (Reset) begin
      in_frame = 0;
      expect_cfg = 1;
      last_rd = 0;
      gap = 1000;
      exp_q.delete();
      miso = 0;
    end else begin
      if (mosi !== prev_mosi && sclk) v_mosi++;
      if (cs_n && sclk) v_idle++;
      if (!cs_n && prev_cs) begin
        if (gap < 2 * CLK_DIV) v_gap++;
        if (last_rd && !expect_cfg && gap > 2 * CLK_DIV + 2) v_b2b++;
        in_frame = 1;
        rises = 0;
        cyc = 0;
        mosi_bits = 0;
        resp[39:24] = 24'($urandom);
        resp[23:0] = 24'($urandom);
        if (!expect_cfg && rd_idx == 0) resp[23:0] = 24'h40C000;
        if (!expect_cfg && rd_idx == 1) resp[23:0] = 24'h7F80FF;
        if (!expect_cfg) rd_idx++;
        miso = resp[39];
      end else if (in_frame && !cs_n) begin
        cyc++;
        if (sclk && !prev_sclk) begin
          if (cyc != (rises == 0 ? CLK_DIV : 2 * CLK_DIV)) v_period++;
          cyc = 0;
          mosi_bits = {mosi_bits[38:0], mosi};
          rises++;
          if (rises < 40) miso = resp[39 - rises];
        end
      end else if (in_frame && cs_n) begin
        cyc++;
        if (cyc != 2 * CLK_DIV) v_period++;
        in_frame = 0;
        gap = 1;
        if (expect_cfg) begin
          check("cfg_bits", rises, 24);
          check("cfg_mosi", mosi_bits[23:0], 24'h0A2D02);
          expect_cfg = 0;
          last_rd = 0;
          n_cfg++;
        end else begin
          check("rd_bits", rises, 40);
          check("rd_mosi", mosi_bits, 40'h0B08000000);
          exp_q.push_back({ref_axis(resp[23:16]), ref_axis(resp[15:8]), ref_axis(resp[7:0])});
          last_rd = 1;
        end
      end else if (cs_n) gap++;
      if (data_valid && prev_dv) v_dvw++;
      else if (data_valid) begin
        check("dv_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("acl_data", acl_data, exp_q.pop_front());
        if (n_dv == 0) check("acl_40_c0_00", acl_data, 15'b0_1000_1_1000_0_0000);
        if (n_dv == 1) check("acl_7f_80_ff", acl_data, 15'b0_1111_1_1111_1_0000);
        n_dv++;
      end else if (acl_data !== prev_acl) v_hold++;
    end
    prev_cs = cs_n;
    prev_sclk = sclk;
    prev_mosi = mosi;
    prev_dv = data_valid;
    prev_acl = acl_data;
  end
  task automatic wait_dv(input int n, input string tag);
    for (int i = 0; i < 20000 && n_dv < n; i++) @(posedge clk);
    check(tag, n_dv >= n, 1'b1);
  endtask
  initial begin
    int saved;
    Reset = 1;
    miso = 0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_acl", acl_data, 15'd0);
    check("rst_dv", data_valid, 1'b0);
    @(posedge clk); #2 Reset = 0;
    wait_dv(4, "dv_first_four");
    for (int i = 0; i < 20000 && !(in_frame && !expect_cfg && rises >= 25 && rises <= 30); i++) @(posedge clk);
    check("byte4_reached", in_frame && !expect_cfg && rises >= 25 && rises <= 30, 1'b1);
    @(posedge clk); #2 Reset = 1;
    saved = n_dv;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_acl", acl_data, 15'd0);
    check("abort_dv", data_valid, 1'b0);
    repeat (3) @(posedge clk);
    #2 Reset = 0;
    check("no_dv_in_rst", n_dv, saved);
    wait_dv(saved + 3, "dv_after_rst");
    @(negedge clk);
    check("cfg_frames", n_cfg, 2);
    check("pending_q", exp_q.size(), 0);
    check("mosi_while_sclk_hi", v_mosi, 0);
    check("sclk_hi_cs_idle", v_idle, 0);
    check("sclk_timing", v_period, 0);
    check("cs_gap_min", v_gap, 0);
    check("read_b2b", v_b2b, 0);
    check("dv_width", v_dvw, 0);
    check("acl_hold", v_hold, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
